// File: rtl/phase_meas_if.sv
// Probe/echo phase-measurement bus: control side (go, echo) and measurement results.
interface phase_meas_if #(
  parameter int unsigned CW         = 7,
  parameter int unsigned NSAMP_LOG2 = 3
) ();
  logic                  go;
  logic                  echo;
  logic                  probe;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         avg;
  logic [CW-1:0]         min_ph;
  logic [CW-1:0]         max_ph;
  logic [NSAMP_LOG2:0]   n_timeout;

  // Controller / echo-path side.
  modport master (
    output go, echo,
    input  probe, busy, done, avg, min_ph, max_ph, n_timeout
  );

  // Sequencer side.
  modport slave (
    input  go, echo,
    output probe, busy, done, avg, min_ph, max_ph, n_timeout
  );
endinterface

// File: rtl/phase_meas_sequencer.sv
// Repeated probe/echo phase measurement: fires a probe, counts ticks to the echo (or
// timeout), repeats 2^NSAMP_LOG2 times, then reports average/min/max and a timeout tally.
module phase_meas_sequencer #(
  parameter int unsigned CW         = 7,
  parameter int unsigned NSAMP_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 100,
  parameter int unsigned GAP        = 4
) (
  input logic         clk,
  input logic         rst,
  phase_meas_if.slave bus
);
  localparam int unsigned SW = CW + NSAMP_LOG2;
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);
  localparam logic [CW-1:0] GapLast = CW'(GAP - 1);
  localparam logic [NSAMP_LOG2:0] IdxLast = (NSAMP_LOG2 + 1)'((1 << NSAMP_LOG2) - 1);

  typedef enum logic [2:0] {StIdle, StFire, StWait, StGap, StFinish} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       tick_q, tick_d, tick_inc;
  logic [NSAMP_LOG2:0] idx_q, idx_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [CW-1:0]       min_q, min_d, max_q, max_d;
  logic [NSAMP_LOG2:0] ntmo_q, ntmo_d;
  logic                sample_valid;

  logic                probe_q, probe_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]       avg_q, avg_d, min_ph_q, min_ph_d, max_ph_q, max_ph_d;
  logic [NSAMP_LOG2:0] n_timeout_q, n_timeout_d;

  // Next-state and sample accumulation. tick doubles as the GAP-phase counter.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    min_d        = min_q;
    max_d        = max_q;
    ntmo_d       = ntmo_q;
    sample_valid = 1'b0;
    tick_inc     = tick_q + CW'(1);
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d = StFire;
          sum_d   = '0;
          idx_d   = '0;
          ntmo_d  = '0;
          tick_d  = '0;
          min_d   = '1;
          max_d   = '0;
        end
      end
      StFire: begin
        tick_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        tick_d = tick_inc;
        // Echo wins over a coincident timeout; the sample value is tick+1 either way.
        if (bus.echo) begin
          sample_valid = 1'b1;
        end else if (tick_inc == TimeoutVal) begin
          sample_valid = 1'b1;
          ntmo_d       = ntmo_q + (NSAMP_LOG2 + 1)'(1);
        end
        if (sample_valid) begin
          tick_d  = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        tick_d = tick_inc;
        if (tick_q == GapLast) begin
          tick_d  = '0;
          idx_d   = idx_q + (NSAMP_LOG2 + 1)'(1);
          state_d = (idx_q == IdxLast) ? StFinish : StFire;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (sample_valid) begin
      sum_d = sum_q + SW'(tick_inc);
      if (tick_inc < min_q) min_d = tick_inc;
      if (tick_inc > max_q) max_d = tick_inc;
    end
  end

  // Registered outputs derived from the upcoming state, so they line up with it.
  always_comb begin
    probe_d     = (state_d == StFire);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFinish);
    avg_d       = avg_q;
    min_ph_d    = min_ph_q;
    max_ph_d    = max_ph_q;
    n_timeout_d = n_timeout_q;
    if (state_d == StFinish) begin
      avg_d       = sum_q[SW-1:NSAMP_LOG2];
      min_ph_d    = min_q;
      max_ph_d    = max_q;
      n_timeout_d = ntmo_q;
    end
  end

  // State, run accumulators and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      ntmo_q      <= '0;
      probe_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      avg_q       <= '0;
      min_ph_q    <= '0;
      max_ph_q    <= '0;
      n_timeout_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      ntmo_q      <= ntmo_d;
      probe_q     <= probe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      avg_q       <= avg_d;
      min_ph_q    <= min_ph_d;
      max_ph_q    <= max_ph_d;
      n_timeout_q <= n_timeout_d;
    end
  end

  assign bus.probe     = probe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.avg       = avg_q;
  assign bus.min_ph    = min_ph_q;
  assign bus.max_ph    = max_ph_q;
  assign bus.n_timeout = n_timeout_q;
endmodule

// File: tb/tb_phase_meas_sequencer.sv
// Directed bench for phase_meas_sequencer with default parameters (N=8, GAP=4, TIMEOUT=100).
module tb_phase_meas_sequencer;
  localparam int CW  = 7;
  localparam int NL  = 3;
  localparam int TMO = 100;
  localparam int GP  = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  int dA[8] = '{5, 5, 5, 5, 5, 5, 5, 5};
  int dB[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
  int dC[8] = '{0, 0, 0, 0, 0, 0, 0, 0};  // 0 = echo never asserted
  int dD[8] = '{100, 100, 100, 100, 100, 100, 100, 100};

  phase_meas_if #(.CW(CW), .NSAMP_LOG2(NL)) bus ();

  phase_meas_sequencer #(
    .CW(CW), .NSAMP_LOG2(NL), .TIMEOUT(TMO), .GAP(GP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run: pulses go, answers each probe after d[s] WAIT cycles (0 = never),
  // optionally adds echo during FIRE/GAP and go pulses while busy.
  task automatic run(input string tag, input int d[8], input bit echo_noise,
                     input bit go_noise, input int exp_done);
    int p = 0, s = 0, cur_d = 0, cur_end = 0, done_cyc = -1;
    bus.go   = 1'b1;
    bus.echo = 1'b0;
    step();
    bus.go = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.busy), 1);
    for (int c = 1; c <= 2000; c++) begin
      if (bus.probe) begin
        if (s == 0) chk({tag, "_first_probe"}, c, 1);
        else        chk({tag, "_probe_gap"}, c - p, 1 + cur_end + GP);
        p       = c;
        cur_d   = (s < 8) ? d[s] : 0;
        cur_end = (cur_d == 0) ? TMO : cur_d;
        s++;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      bus.echo = (s > 0 && cur_d != 0 && c == p + cur_d) ||
                 (echo_noise && s > 0 && (c == p || (c > p + cur_end && c <= p + cur_end + GP)));
      bus.go = go_noise && c >= 20 && c <= 25;
      step();
    end
    bus.echo = 1'b0;
    bus.go   = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_probe_count"}, s, 8);
    step();
    chk({tag, "_busy_after"}, 32'(bus.busy), 0);
    chk({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  task automatic chk_results(input string tag, input int a, input int mn, input int mx,
                             input int nt);
    chk({tag, "_avg"}, 32'(bus.avg), a);
    chk({tag, "_min"}, 32'(bus.min_ph), mn);
    chk({tag, "_max"}, 32'(bus.max_ph), mx);
    chk({tag, "_ntmo"}, 32'(bus.n_timeout), nt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_probe"}, 32'(bus.probe), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk_results(tag, 0, 0, 0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.go   = 1'b0;
    bus.echo = 1'b0;
    step();
    step();
    chk_zero("rst0");
    rst = 1'b0;
    step();

    // Constant echo at k=5.
    run("A", dA, 1'b0, 1'b0, 81);
    chk_results("A", 5, 5, 5, 0);

    // Asynchronous reset mid-WAIT discards the run and clears results.
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    step();
    step();
    chk("R_busy_pre", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("R_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Mixed delays, fresh run after reset: sum 37 -> avg 4.
    run("B", dB, 1'b0, 1'b0, 78);
    chk_results("B", 4, 1, 9, 0);

    // Echo never arrives: every sample times out.
    run("C", dC, 1'b0, 1'b0, 841);
    chk_results("C", 100, 100, 100, 8);

    // Echo on the 100th WAIT cycle beats the timeout.
    run("D", dD, 1'b0, 1'b0, 841);
    chk_results("D", 100, 100, 100, 0);

    // Echo during FIRE/GAP and go while busy must not disturb anything.
    run("E", dB, 1'b1, 1'b1, 78);
    chk_results("E", 4, 1, 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_meas_sequencer.md
# phase_meas_sequencer

Drives repeated probe/echo phase measurements for the ADC board clock-alignment logic. On a request, it fires a one-cycle probe pulse, counts `clk` ticks until the echo returns or a timeout expires, and repeats for 2^NSAMP_LOG2 samples. It then reports the average, minimum and maximum tick counts plus a timeout tally. It sits between the control/register interface (which issues `go` and reads results) and the probe/echo path.

## Interface
- CW, 7: tick-count and result width; TIMEOUT must be ≤ 2^CW−1.
- NSAMP_LOG2, 3: log2 of samples per run (default 8 samples).
- TIMEOUT, 100: WAIT cycles without echo before a sample is declared timed out.
- GAP, 4: idle cycles after each sample, letting the echo path settle; ≥1.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start a run; sampled only in IDLE.
- echo  in  1  stop/echo signal, already synchronous to `clk`.
- probe  out  1  one-cycle start pulse per sample.
- busy  out  1  high from the cycle after `go` is accepted through the FINISH cycle.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- avg  out  CW  floor(sum of samples / 2^NSAMP_LOG2).
- min_ph  out  CW  smallest sample of the run.
- max_ph  out  CW  largest sample of the run.
- n_timeout  out  NSAMP_LOG2+1  count of timed-out samples in the run.

## Operation
- States: IDLE, FIRE, WAIT, GAP, FINISH.
- IDLE: when `go`=1, clear sum, idx, timeout tally and tick; set running min to all-ones and running max to 0; go to FIRE.
- FIRE: `probe`=1 for this cycle only; tick←0; go to WAIT. `echo` is ignored in FIRE.
- WAIT: tick←tick+1 each cycle.
  - If `echo`=1, the sample is tick+1 (echo seen in the first WAIT cycle gives sample 1). Go to GAP.
  - Otherwise, if tick+1 = TIMEOUT, the sample is TIMEOUT, n_timeout increments, and the state goes to GAP.
  - If `echo` arrives in the same cycle as the timeout, the echo wins: sample = TIMEOUT, no timeout is counted.
- Sample update: sum += sample (width CW+NSAMP_LOG2, no overflow possible); min/max are updated by unsigned compare.
- GAP: wait GAP cycles; `echo` is ignored. On the last GAP cycle, idx←idx+1. If the new idx = 2^NSAMP_LOG2, go to FINISH; else go to FIRE.
- FINISH: load `avg`=sum>>NSAMP_LOG2 (truncating), `min_ph`, `max_ph` and `n_timeout` into output registers. Pulse `done` for one cycle, then go to IDLE.
- Outputs hold their values until the next FINISH.
- `go` while busy is ignored; it is not queued.
- `go` held high in IDLE after FINISH starts a new run.
- Reset: asynchronous, applies at any time including mid-run. State←IDLE; `probe`, `busy`, `done`, `avg`, `min_ph`, `max_ph`, `n_timeout` all ←0. Any partial run is discarded.

## Timing
- `go` is sampled at edge E0; FIRE (with `probe` high) occupies the cycle after E0.
- Each sample costs 1 (FIRE) + k (WAIT, k = sample value) + GAP cycles.
- `done` rises N·(1+k+GAP)+1 cycles after E0, with N = 2^NSAMP_LOG2 and constant k.
- All outputs are registered; there is no combinational path from `echo` or `go` to any output.
- `busy` falls in the cycle after `done`, when the state returns to IDLE.

## Test plan
- Reset mid-WAIT: assert `rst` asynchronously during WAIT. All outputs go to 0 immediately; `go` one cycle after release starts a fresh run with `probe` 1 cycle later.
- Constant echo at k=5 (defaults: N=8, GAP=4, TIMEOUT=100):
  - `done` exactly 81 cycles after the `go` edge.
  - `avg`=`min_ph`=`max_ph`=5, `n_timeout`=0, 8 `probe` pulses spaced 10 cycles apart.
- Echo delays 1,2,3,4,5,6,7,9: `avg`=4 (37>>3), `min_ph`=1, `max_ph`=9.
- `echo` never asserted:
  - each sample is 100 and `n_timeout`=8;
  - `avg`=`min_ph`=`max_ph`=100;
  - `done` at 8·105+1=841 cycles.
- Boundary cases:
  - echo exactly on the 100th WAIT cycle gives sample 100 with `n_timeout`=0;
  - echo during FIRE or GAP is ignored and the sample uses the next WAIT-phase echo;
  - `go` pulsed while busy does not change `done` timing or results.
